lc3_writeback: RTL and testbench

- LC3 writeback stage. Selects the result to commit, writes it into the 8x16 general-purpose register file, updates the 3-bit PSR condition codes, and returns registered read data on VSR1/VSR2.
- Drives the writeback_out bus: psr, VSR1, VSR2 and enable_writeback_status.
- Sits after the execute and memory-access stages. Its read ports feed the execute stage operands.

---
 rtl/lc3_writeback.sv | 114 +++++++++++
 tb/tb_lc3_writeback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: result select, 8x16 register file, PSR condition codes, registered read ports.
// Optional macro LC3_WRITEBACK_BYPASS_EN forwards a same-edge write to the read ports.
module lc3_writeback #(
    parameter int         DATA_W    = 16,
    parameter int         NUM_REGS  = 8,
    parameter logic [2:0] PSR_RESET = 3'b000,
    localparam int        ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_writeback,
    input  logic [1:0]        W_Control,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] pcout,
    input  logic [DATA_W-1:0] memout,
    input  logic [ADDR_W-1:0] dr,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    output logic [2:0]        psr,
    output logic [DATA_W-1:0] VSR1,
    output logic [DATA_W-1:0] VSR2,
    output logic              enable_writeback_status
);

    logic [DATA_W-1:0] dr_in;
    logic              write_en;
    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic [2:0]        psr_reg;
    logic [2:0]        psr_next;
    logic [DATA_W-1:0] vsr1_reg;
    logic [DATA_W-1:0] vsr1_next;
    logic [DATA_W-1:0] vsr2_reg;
    logic [DATA_W-1:0] vsr2_next;
    logic              status_reg;

    always_comb begin
        dr_in = memout;
        case (W_Control)
            2'd0:    dr_in = aluout;
            2'd1:    dr_in = pcout;
            default: dr_in = memout;
        endcase
    end

    // Select value 3 is the "no write" code and overrides the commit strobe.
    assign write_en = enable_writeback && (W_Control != 2'd3);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rf
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    entry_reg <= '0;
                end else if (write_en && (dr == ADDR_W'(gi))) begin
                    entry_reg <= dr_in;
                end
            end

            assign rf_q[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        psr_next = psr_reg;
        if (write_en) begin
            if (dr_in[DATA_W-1]) begin
                psr_next = 3'b100;
            end else if (dr_in == '0) begin
                psr_next = 3'b010;
            end else begin
                psr_next = 3'b001;
            end
        end
    end

    always_comb begin
        vsr1_next = rf_q[sr1];
        vsr2_next = rf_q[sr2];
`ifdef LC3_WRITEBACK_BYPASS_EN
        if (write_en && (dr == sr1)) begin
            vsr1_next = dr_in;
        end
        if (write_en && (dr == sr2)) begin
            vsr2_next = dr_in;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            psr_reg    <= PSR_RESET;
            vsr1_reg   <= '0;
            vsr2_reg   <= '0;
            status_reg <= 1'b0;
        end else begin
            psr_reg    <= psr_next;
            vsr1_reg   <= vsr1_next;
            vsr2_reg   <= vsr2_next;
            status_reg <= enable_writeback;
        end
    end

    assign psr                     = psr_reg;
    assign VSR1                    = vsr1_reg;
    assign VSR2                    = vsr2_reg;
    assign enable_writeback_status = status_reg;

    // Unknown select or destination during a commit would corrupt the register file silently.
    a_no_x_on_commit: assert property (@(posedge clock) disable iff (!reset)
        enable_writeback |-> !$isunknown({W_Control, dr}));

endmodule

// File: tb/tb_lc3_writeback.sv
// Bench for lc3_writeback: directed steps plus random traffic against an array-based register model.
module tb_lc3_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_writeback;
    logic [1:0]  W_Control;
    logic [15:0] aluout;
    logic [15:0] pcout;
    logic [15:0] memout;
    logic [2:0]  dr;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [2:0]  psr;
    logic [15:0] VSR1;
    logic [15:0] VSR2;
    logic        enable_writeback_status;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf_m [8];
    logic [2:0]  psr_m;
    logic [15:0] v1_m;
    logic [15:0] v2_m;
    logic        ews_m;

    lc3_writeback dut (
        .clock                   (clock),
        .reset                   (reset),
        .enable_writeback        (enable_writeback),
        .W_Control               (W_Control),
        .aluout                  (aluout),
        .pcout                   (pcout),
        .memout                  (memout),
        .dr                      (dr),
        .sr1                     (sr1),
        .sr2                     (sr2),
        .psr                     (psr),
        .VSR1                    (VSR1),
        .VSR2                    (VSR2),
        .enable_writeback_status (enable_writeback_status)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])          return 3'b100;
        else if (v == 16'h0) return 3'b010;
        else                return 3'b001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) rf_m[i] = 16'h0;
        psr_m = 3'b000;
        v1_m  = 16'h0;
        v2_m  = 16'h0;
        ews_m = 1'b0;
    endtask

    // Applies one clock edge of the architectural behaviour to the model.
    task automatic model_edge();
        logic [15:0] val;
        logic        wr;
        val = (W_Control == 2'd0) ? aluout : (W_Control == 2'd1) ? pcout : memout;
        wr  = enable_writeback && (W_Control != 2'd3);
        v1_m = rf_m[sr1];
        v2_m = rf_m[sr2];
`ifdef LC3_WRITEBACK_BYPASS_EN
        if (wr && dr == sr1) v1_m = val;
        if (wr && dr == sr2) v2_m = val;
`endif
        if (wr) begin
            rf_m[dr] = val;
            psr_m    = cc_of(val);
        end
        ews_m = enable_writeback;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".psr"},  {13'h0, psr}, {13'h0, psr_m});
        chk({tag, ".vsr1"}, VSR1, v1_m);
        chk({tag, ".vsr2"}, VSR2, v2_m);
        chk({tag, ".ews"},  {15'h0, enable_writeback_status}, {15'h0, ews_m});
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_all(tag);
        $display("%0t %s en=%0d wc=%0d dr=%0d sr1=%0d sr2=%0d psr=%b vsr1=%h vsr2=%h ews=%0d",
                 $time, tag, enable_writeback, W_Control, dr, sr1, sr2, psr, VSR1, VSR2,
                 enable_writeback_status);
    endtask

    task automatic set_write(input logic [1:0] wc, input logic [15:0] val, input logic [2:0] d);
        enable_writeback = 1'b1;
        W_Control        = wc;
        aluout           = val;
        pcout            = val;
        memout           = val;
        dr               = d;
    endtask

    initial begin
        reset = 1'b0;
        enable_writeback = 1'b0;
        W_Control = 2'd0;
        aluout = 16'h0; pcout = 16'h0; memout = 16'h0;
        dr = 3'd0; sr1 = 3'd0; sr2 = 3'd0;
        model_reset();

        // Reset then idle
        repeat (3) @(posedge clock);
        #1;
        check_all("reset_hold");
        reset = 1'b1;
        sr1 = 3'd0; sr2 = 3'd7;
        step("idle");
        chk("idle.psr_lit", {13'h0, psr}, 16'h0000);

        // Source select, dr=3
        set_write(2'd0, 16'h1234, 3'd3); pcout = 16'hDEAD; memout = 16'hBEEF;
        sr1 = 3'd3;
        step("wr_alu");
        enable_writeback = 1'b0;
        step("rd_alu");
        chk("alu.vsr1_lit", VSR1, 16'h1234);
        chk("alu.psr_lit", {13'h0, psr}, 16'h0001);

        set_write(2'd1, 16'h8000, 3'd3); aluout = 16'h0001; memout = 16'h0002;
        step("wr_pc");
        enable_writeback = 1'b0;
        step("rd_pc");
        chk("pc.vsr1_lit", VSR1, 16'h8000);
        chk("pc.psr_lit", {13'h0, psr}, 16'h0004);

        set_write(2'd2, 16'h0000, 3'd3); aluout = 16'h7777; pcout = 16'h9999;
        step("wr_mem");
        enable_writeback = 1'b0;
        step("rd_mem");
        chk("mem.vsr1_lit", VSR1, 16'h0000);
        chk("mem.psr_lit", {13'h0, psr}, 16'h0002);

        // Suppressed write
        set_write(2'd0, 16'h00AA, 3'd5);
        step("wr_r5");
        set_write(2'd3, 16'hFFFF, 3'd5);
        sr1 = 3'd5; sr2 = 3'd5;
        step("wr_suppressed");
        chk("suppress.ews_lit", {15'h0, enable_writeback_status}, 16'h0001);
        chk("suppress.psr_lit", {13'h0, psr}, 16'h0001);
        enable_writeback = 1'b0;
        step("rd_r5");
        chk("suppress.vsr1_lit", VSR1, 16'h00AA);

        // Read during write
        set_write(2'd0, 16'h0011, 3'd2);
        sr1 = 3'd0; sr2 = 3'd0;
        step("wr_r2_old");
        set_write(2'd0, 16'h0022, 3'd2);
        sr1 = 3'd2;
        step("rdw_same_edge");
`ifdef LC3_WRITEBACK_BYPASS_EN
        chk("rdw.vsr1_lit", VSR1, 16'h0022);
`else
        chk("rdw.vsr1_lit", VSR1, 16'h0011);
`endif
        enable_writeback = 1'b0;
        step("rdw_after");
        chk("rdw_after.vsr1_lit", VSR1, 16'h0022);

        // Back-to-back writes
        sr1 = 3'd0; sr2 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            set_write(2'd0, 16'h0100 + 16'(i), 3'(i));
            step("b2b_wr");
        end
        enable_writeback = 1'b0;
        chk("b2b.psr_lit", {13'h0, psr}, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            sr1 = 3'(2 * i);
            sr2 = 3'(2 * i + 1);
            step("b2b_rd");
            chk("b2b.vsr1_lit", VSR1, 16'h0100 + 16'(2 * i));
            chk("b2b.vsr2_lit", VSR2, 16'h0100 + 16'(2 * i + 1));
        end

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            enable_writeback = 1'($urandom);
            W_Control = 2'($urandom);
            aluout = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            pcout  = 16'($urandom);
            memout = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            dr  = 3'($urandom);
            sr1 = 3'($urandom);
            sr2 = ($urandom_range(0, 3) == 0) ? sr1 : 3'($urandom);
            step("rand");
        end

        // Reset mid-operation
        set_write(2'd0, 16'h1111, 3'd4);
        step("wr_r4_pre");
        set_write(2'd0, 16'hBEEF, 3'd4);
        sr1 = 3'd4; sr2 = 3'd4;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clock);
        #1;
        check_all("reset_edge_no_write");
        enable_writeback = 1'b0;
        reset = 1'b1;
        step("post_reset_rd");
        chk("post_reset.vsr1_lit", VSR1, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
